// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode, flag and FSM-state types shared by the sequential ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SLT   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_MUL   = 4'd10,
    ALU_MULHU = 4'd11
  } alu_op_t;

  typedef struct packed {
    logic err;
    logic ovf;
    logic carry;
    logic neg;
    logic zero;
  } alu_flags_t;

  localparam logic [3:0] ALU_OP_LAST = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } alu_state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULHU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ============================================================================
// Module   : alu_mul_seq
// Brief    : Iterative radix-2 unsigned shift-add multiplier, one step/cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int c_CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_busy;

  logic [2*WIDTH-1:0] w_prod_next;
  logic               w_last;

  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_last      = r_busy && (r_cnt == c_CNT_W'(WIDTH - 1));

  // The final step's sum is exposed directly so the result lands on the same edge.
  assign done    = w_last;
  assign product = w_prod_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module   : alu_seq
// Brief    : Registered ALU with valid/ready handshake and iterative multiply.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  localparam int c_SH_W = $clog2(WIDTH);

  alu_state_t         r_state;
  alu_state_t         w_state_next;
  logic               r_out_valid;
  logic               w_out_valid_next;
  logic [WIDTH-1:0]   r_result;
  alu_flags_t         r_flags;
  logic               r_mul_hi;

  logic               w_in_ready;
  logic               w_in_fire;
  logic               w_illegal;
  logic               w_mul_start;
  logic               w_load_single;
  logic               w_load_mul;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;
  logic [WIDTH-1:0]   w_mul_res;

  logic [c_SH_W-1:0]  w_shamt;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_carry;
  logic               w_ovf;
  alu_flags_t         w_single_flags;

  assign w_shamt   = b[c_SH_W-1:0];
  assign w_sum     = {1'b0, a} + {1'b0, b};
  assign w_diff    = {1'b0, a} - {1'b0, b};
  assign w_illegal = (alu_op > ALU_OP_LAST) || (!MUL_EN && is_mul_op(alu_op));

  always_comb begin
    w_alu_res = '0;
    w_carry   = 1'b0;
    w_ovf     = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_carry   = w_sum[WIDTH];
        w_ovf     = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_carry   = w_diff[WIDTH];
        w_ovf     = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:  w_alu_res = a & b;
      ALU_OR:   w_alu_res = a | b;
      ALU_XOR:  w_alu_res = a ^ b;
      ALU_SLL:  w_alu_res = a << w_shamt;
      ALU_SRL:  w_alu_res = a >> w_shamt;
      ALU_SRA:  w_alu_res = $unsigned($signed(a) >>> w_shamt);
      ALU_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default:  w_alu_res = '0;
    endcase
  end

  // Illegal opcodes report err alone, even though their zero result would set zero.
  always_comb begin
    w_single_flags = '0;
    if (w_illegal) begin
      w_single_flags.err = 1'b1;
    end else begin
      w_single_flags.ovf   = w_ovf;
      w_single_flags.carry = w_carry;
      w_single_flags.neg   = w_alu_res[WIDTH-1];
      w_single_flags.zero  = (w_alu_res == '0);
    end
  end

  generate
    if (MUL_EN) begin : g_mul_on
      alu_mul_seq #(
        .WIDTH   (WIDTH)
      ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (a),
        .b       (b),
        .done    (w_mul_done),
        .product (w_mul_prod)
      );
    end else begin : g_mul_off
      assign w_mul_done = 1'b0;
      assign w_mul_prod = '0;
    end
  endgenerate

  assign w_mul_res  = r_mul_hi ? w_mul_prod[2*WIDTH-1:WIDTH] : w_mul_prod[WIDTH-1:0];
  assign w_in_ready = !rst && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_in_fire  = in_valid && w_in_ready;

  always_comb begin
    w_state_next     = r_state;
    w_out_valid_next = r_out_valid && !out_ready;
    w_mul_start      = 1'b0;
    w_load_single    = 1'b0;
    w_load_mul       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_in_fire) begin
          if (is_mul_op(alu_op) && !w_illegal) begin
            w_mul_start      = 1'b1;
            w_out_valid_next = 1'b0;
            w_state_next     = ST_MUL;
          end else begin
            w_load_single    = 1'b1;
            w_out_valid_next = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (w_mul_done) begin
          w_load_mul       = 1'b1;
          w_out_valid_next = 1'b1;
          w_state_next     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_mul_hi    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= w_out_valid_next;
      if (w_mul_start) begin
        r_mul_hi <= (alu_op == ALU_MULHU);
      end
      if (w_load_single) begin
        r_result <= w_alu_res;
        r_flags  <= w_single_flags;
      end else if (w_load_mul) begin
        r_result      <= w_mul_res;
        r_flags       <= '0;
        r_flags.neg   <= w_mul_res[WIDTH-1];
        r_flags.zero  <= (w_mul_res == '0);
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

`default_nettype wire
